// File: rtl/alarm_sequencer_pkg.sv
// Shared types and constants for the alarm sequencer and its display consumers.
package alarm_sequencer_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_SET     = 2'd1,
        STATE_TRIGGER = 2'd2,
        STATE_ALERT   = 2'd3
    } fsm_state_t;

    localparam int unsigned DIGIT_W   = 4;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;

endpackage

// File: rtl/alarm_sequencer_tick.sv
// One-second strobe generator: counts 0..CLK_HZ-1 while enabled, cleared when disabled.
module tick_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned    CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || count == CNT_MAX) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Strobe aligns with the wrap so the consumer updates on the same edge the count restarts.
    assign tick = en && (count == CNT_MAX);

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm master controller: arming, trigger countdown and passcode entry/compare.
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned TRIGGER_SECS = 30,
    parameter int unsigned CODE_LEN     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_req,
    input  logic             sensor,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    output fsm_state_t       system_state,
    output int               timer,
    output logic [3:0]       current_value,
    output logic             code_ok,
    output logic             code_err
);

    localparam int unsigned      BUF_W    = CODE_LEN * DIGIT_W;
    localparam int unsigned      CNT_W    = $clog2(CODE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CODE_LEN);

    fsm_state_t       state_n;
    int               timer_n;
    logic [3:0]       value_n;
    logic             ok_n;
    logic             err_n;
    logic [BUF_W-1:0] code, code_n;
    logic [BUF_W-1:0] entry, entry_n, entry_sh;
    logic [CNT_W-1:0] count, count_n, count_sh;
    logic             digit_ok;
    logic             full;
    logic             compare;
    logic             match;
    logic             tick_en;
    logic             tick;

    assign tick_en = (system_state == STATE_TRIGGER);

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            system_state  <= STATE_IDLE;
            timer         <= 0;
            current_value <= '0;
            code_ok       <= 1'b0;
            code_err      <= 1'b0;
            code          <= '0;
            entry         <= '0;
            count         <= '0;
        end else begin
            system_state  <= state_n;
            timer         <= timer_n;
            current_value <= value_n;
            code_ok       <= ok_n;
            code_err      <= err_n;
            code          <= code_n;
            entry         <= entry_n;
            count         <= count_n;
        end
    end

    always_comb begin
        // Digit shift happens before any decision so arming and compares see the new digit.
        digit_ok = digit_valid && (digit <= DIGIT_MAX);
        entry_sh = digit_ok ? BUF_W'({entry, digit}) : entry;
        count_sh = (digit_ok && count != CNT_FULL) ? count + CNT_W'(1) : count;
        full     = (count_sh == CNT_FULL);
        compare  = digit_ok && full;
        match    = compare && (entry_sh == code);

        state_n = system_state;
        timer_n = timer;
        value_n = digit_ok ? digit : current_value;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        code_n  = code;
        entry_n = entry_sh;
        count_n = count_sh;

        case (system_state)
            STATE_IDLE: begin
                if (arm_req) begin
                    if (full) begin
                        code_n  = entry_sh;
                        state_n = STATE_SET;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            STATE_SET: begin
                if (match) begin
                    state_n = STATE_IDLE;
                    ok_n    = 1'b1;
                end else if (sensor) begin
                    state_n = STATE_TRIGGER;
                    timer_n = int'(TRIGGER_SECS);
                end
            end
            STATE_TRIGGER: begin
                // A correct code beats a concurrent tick, even the one that would enter ALERT.
                if (match) begin
                    state_n = STATE_IDLE;
                    timer_n = 0;
                    ok_n    = 1'b1;
                end else begin
                    if (compare) begin
                        err_n   = 1'b1;
                        entry_n = '0;
                        count_n = '0;
                    end
                    if (tick) begin
                        if (timer <= 1) begin
                            state_n = STATE_ALERT;
                            timer_n = 0;
                        end else begin
                            timer_n = timer - 1;
                        end
                    end
                end
            end
            STATE_ALERT: begin
                timer_n = 0;
                if (match) begin
                    state_n = STATE_IDLE;
                    ok_n    = 1'b1;
                end else if (compare) begin
                    err_n   = 1'b1;
                    entry_n = '0;
                    count_n = '0;
                end
            end
            default: begin
                state_n = STATE_IDLE;
            end
        endcase

        if (state_n != system_state) begin
            entry_n = '0;
            count_n = '0;
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer with a 10-cycle second and 3 s countdown.
module tb_alarm_sequencer;
    import alarm_sequencer_pkg::*;

    logic       clk;
    logic       rst;
    logic       arm_req;
    logic       sensor;
    logic       digit_valid;
    logic [3:0] digit;
    fsm_state_t system_state;
    int         timer;
    logic [3:0] current_value;
    logic       code_ok;
    logic       code_err;

    int checks;
    int errors;

    alarm_sequencer #(
        .CLK_HZ       (10),
        .TRIGGER_SECS (3),
        .CODE_LEN     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm_req       (arm_req),
        .sensor        (sensor),
        .digit_valid   (digit_valid),
        .digit         (digit),
        .system_state  (system_state),
        .timer         (timer),
        .current_value (current_value),
        .code_ok       (code_ok),
        .code_err      (code_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit       = d;
        digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        send_digit(a);
        send_digit(b);
        send_digit(c);
        send_digit(d);
    endtask

    task automatic arm();
        arm_req = 1'b1;
        step();
        arm_req = 1'b0;
    endtask

    task automatic pulse_sensor();
        sensor = 1'b1;
        step();
        sensor = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        arm_req     = 1'b0;
        sensor      = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;

        // Reset values and basic arming
        do_reset();
        check("rst_state", int'(system_state), int'(STATE_IDLE));
        check("rst_timer", timer, 0);
        check("rst_value", int'(current_value), 0);
        check("rst_ok", int'(code_ok), 0);
        check("rst_err", int'(code_err), 0);
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        check("t1_value", int'(current_value), 4);
        arm();
        check("t1_state", int'(system_state), int'(STATE_SET));
        check("t1_err", int'(code_err), 0);
        arm();
        check("t1_rearm_ignored", int'(system_state), int'(STATE_SET));
        check("t1_rearm_err", int'(code_err), 0);

        // Short code: arming refused, invalid digit ignored
        do_reset();
        send_digit(4'd1);
        send_digit(4'd2);
        send_digit(4'd12);
        check("t2_bad_digit_value", int'(current_value), 2);
        arm();
        check("t2_err", int'(code_err), 1);
        check("t2_state", int'(system_state), int'(STATE_IDLE));
        step();
        check("t2_err_pulse", int'(code_err), 0);

        // Countdown to ALERT
        do_reset();
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        arm();
        pulse_sensor();
        check("t3_state_trig", int'(system_state), int'(STATE_TRIGGER));
        check("t3_timer_load", timer, 3);
        repeat (9) step();
        check("t3_timer_c9", timer, 3);
        step();
        check("t3_timer_c10", timer, 2);
        repeat (10) step();
        check("t3_timer_c20", timer, 1);
        check("t3_state_c20", int'(system_state), int'(STATE_TRIGGER));
        repeat (10) step();
        check("t3_state_c30", int'(system_state), int'(STATE_ALERT));
        check("t3_timer_c30", timer, 0);
        sensor = 1'b1;
        repeat (3) step();
        sensor = 1'b0;
        check("t3_alert_sensor", int'(system_state), int'(STATE_ALERT));
        check("t3_alert_timer", timer, 0);
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        check("t3_alert_ok", int'(code_ok), 1);
        check("t3_alert_idle", int'(system_state), int'(STATE_IDLE));

        // Wrong then right code during countdown
        do_reset();
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        arm();
        pulse_sensor();
        enter_code(4'd1, 4'd2, 4'd3, 4'd5);
        check("t4_bad_err", int'(code_err), 1);
        check("t4_bad_ok", int'(code_ok), 0);
        check("t4_bad_state", int'(system_state), int'(STATE_TRIGGER));
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        check("t4_good_ok", int'(code_ok), 1);
        check("t4_good_state", int'(system_state), int'(STATE_IDLE));
        check("t4_good_timer", timer, 0);
        step();
        check("t4_ok_pulse", int'(code_ok), 0);

        // Disarm on the same cycle as the final tick
        do_reset();
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        arm();
        pulse_sensor();
        repeat (26) step();
        check("t5_timer_pre", timer, 1);
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        check("t5_ok", int'(code_ok), 1);
        check("t5_state", int'(system_state), int'(STATE_IDLE));
        check("t5_timer", timer, 0);
        step();
        check("t5_no_alert", int'(system_state), int'(STATE_IDLE));

        // Asynchronous reset from ALERT, then mid-entry
        do_reset();
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        arm();
        pulse_sensor();
        repeat (30) step();
        check("t6_in_alert", int'(system_state), int'(STATE_ALERT));
        send_digit(4'd7);
        check("t6_value_pre", int'(current_value), 7);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_state", int'(system_state), int'(STATE_IDLE));
        check("t6_async_timer", timer, 0);
        check("t6_async_value", int'(current_value), 0);
        step();
        rst = 1'b0;
        arm();
        check("t6_old_code_err", int'(code_err), 1);
        check("t6_old_code_state", int'(system_state), int'(STATE_IDLE));
        send_digit(4'd1);
        send_digit(4'd2);
        do_reset();
        send_digit(4'd3);
        send_digit(4'd4);
        arm();
        check("t6_mid_entry_err", int'(code_err), 1);
        check("t6_mid_entry_state", int'(system_state), int'(STATE_IDLE));

        // Final digit and arm_req in the same cycle
        do_reset();
        send_digit(4'd5);
        send_digit(4'd6);
        send_digit(4'd7);
        digit       = 4'd8;
        digit_valid = 1'b1;
        arm_req     = 1'b1;
        step();
        digit_valid = 1'b0;
        arm_req     = 1'b0;
        check("t7_same_cycle_state", int'(system_state), int'(STATE_SET));
        check("t7_same_cycle_err", int'(code_err), 0);
        enter_code(4'd5, 4'd6, 4'd7, 4'd8);
        check("t7_set_disarm_ok", int'(code_ok), 1);
        check("t7_set_disarm_state", int'(system_state), int'(STATE_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
